// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY transmit-path definitions.
// Symbol constants, default sizes and framing flags.
package pcie_phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_OUT_LAT = 2;

  typedef struct packed {
    logic start;
    logic is_data;
    logic underrun;
  } frame_flags_t;

endpackage

// File: rtl/bit_delay_line.sv
// Fixed-depth register pipeline with async clear.
// Carries serial bit plus framing flags to the pins.
module bit_delay_line #(
  parameter int DW = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk32f,
  input  logic          reset,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] stage [DEPTH];

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/serializer_param.sv
// Parallel-to-serial symbol converter with idle insertion.
// One-entry holding buffer sustains full line rate.
module serializer_param
  import pcie_phy_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(COM_SYM),
  parameter bit               MSB_FIRST = 1'b1,
  parameter int               OUT_LAT   = DEF_OUT_LAT
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_sym_start,
  output logic             out_is_data,
  output logic             underrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  logic [WIDTH-1:0] hold_buf;
  logic [WIDTH-1:0] shreg;
  logic             hold_full;
  logic             data_flag;
  logic             prev_data_flag;
  logic [CW-1:0]    bit_cnt;
  logic             load;
  logic             accept;

  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign load     = (bit_cnt == LAST);

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      hold_buf       <= '0;
      hold_full      <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= LAST;
      data_flag      <= 1'b0;
      prev_data_flag <= 1'b0;
    end else if (load) begin
      bit_cnt        <= '0;
      prev_data_flag <= data_flag;
      if (hold_full) begin
        shreg     <= hold_buf;
        hold_full <= 1'b0;
        data_flag <= 1'b1;
      end else if (accept) begin
        shreg     <= in;
        data_flag <= 1'b1;
      end else begin
        shreg     <= IDLE_SYM;
        data_flag <= 1'b0;
      end
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
      shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      if (accept) begin
        hold_buf  <= in;
        hold_full <= 1'b1;
      end
    end
  end

  logic         pre_bit;
  frame_flags_t pre_flags;
  frame_flags_t out_flags;
  logic [3:0]   pipe_q;

  assign pre_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  // underrun marks the first idle after a data symbol
  always_comb begin
    pre_flags          = '0;
    pre_flags.start    = (bit_cnt == '0);
    pre_flags.is_data  = data_flag;
    pre_flags.underrun = (bit_cnt == '0) && !data_flag && prev_data_flag;
  end

  bit_delay_line #(
    .DW   (4),
    .DEPTH(OUT_LAT)
  ) u_dly (
    .clk32f(clk32f),
    .reset (reset),
    .d     ({pre_bit, pre_flags}),
    .q     (pipe_q)
  );

  assign out           = pipe_q[3];
  assign out_flags     = pipe_q[2:0];
  assign out_sym_start = out_flags.start;
  assign out_is_data   = out_flags.is_data;
  assign underrun      = out_flags.underrun;

endmodule

// File: tb/tb_serializer_param.sv
// Randomized bench for serializer_param in three configurations.
// A symbol-level model predicts every output bit and in_ready.
module tb_serializer_param;

  logic       clk32f = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] din = '0;
  logic [2:0] vld = '0;
  logic [2:0] rdy, o_bit, o_st, o_dat, o_und;

  always #5 clk32f = ~clk32f;

  serializer_param #(
    .WIDTH(8), .IDLE_SYM(8'hBC), .MSB_FIRST(1'b1), .OUT_LAT(2)
  ) u_msb (
    .clk32f(clk32f), .reset(reset), .in(din[7:0]),
    .in_valid(vld[0]), .in_ready(rdy[0]), .out(o_bit[0]),
    .out_sym_start(o_st[0]), .out_is_data(o_dat[0]),
    .underrun(o_und[0])
  );

  serializer_param #(
    .WIDTH(8), .IDLE_SYM(8'hBC), .MSB_FIRST(1'b0), .OUT_LAT(2)
  ) u_lsb (
    .clk32f(clk32f), .reset(reset), .in(din[7:0]),
    .in_valid(vld[1]), .in_ready(rdy[1]), .out(o_bit[1]),
    .out_sym_start(o_st[1]), .out_is_data(o_dat[1]),
    .underrun(o_und[1])
  );

  serializer_param #(
    .WIDTH(10), .IDLE_SYM(10'h17C), .MSB_FIRST(1'b1), .OUT_LAT(1)
  ) u_w10 (
    .clk32f(clk32f), .reset(reset), .in(din),
    .in_valid(vld[2]), .in_ready(rdy[2]), .out(o_bit[2]),
    .out_sym_start(o_st[2]), .out_is_data(o_dat[2]),
    .underrun(o_und[2])
  );

  int         errors = 0;
  int         checks = 0;
  int         sel, cw, cl;
  bit         cmsb;
  logic [9:0] cidle;

  logic [9:0] q[$];
  logic [3:0] stream[$];
  int         n;
  bit         prev_dat;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d edge=%0d: got %0h expected %0h",
               tag, sel, n, got, exp);
    end
  endtask

  task automatic use_dut(input int s);
    sel = s;
    case (s)
      0: begin cw = 8;  cl = 2; cmsb = 1'b1; cidle = 10'h0BC; end
      1: begin cw = 8;  cl = 2; cmsb = 1'b0; cidle = 10'h0BC; end
      default: begin cw = 10; cl = 1; cmsb = 1'b1; cidle = 10'h17C; end
    endcase
  endtask

  task automatic model_clear();
    q.delete();
    stream.delete();
    n = 0;
    prev_dat = 1'b0;
  endtask

  // Symbol schedule: a new symbol starts every cw edges from release
  task automatic model_edge(input bit v, input logic [9:0] d);
    logic [9:0] m, sym;
    bit dat, und, acc;
    m = (10'h1 << cw) - 10'h1;
    acc = v && (q.size() == 0);
    if (n % cw == 0) begin
      if (q.size() != 0) begin
        sym = q.pop_front();
        dat = 1'b1;
      end else if (acc) begin
        sym = d & m;
        dat = 1'b1;
      end else begin
        sym = cidle;
        dat = 1'b0;
      end
      und = !dat && prev_dat;
      prev_dat = dat;
      for (int b = 0; b < cw; b++)
        stream.push_back({cmsb ? sym[cw-1-b] : sym[b],
                          b == 0, dat, (b == 0) && und});
    end else if (acc) begin
      q.push_back(d & m);
    end
    n++;
  endtask

  function automatic logic [3:0] exp_out();
    int e;
    e = n - 1 - cl;
    return (e < 0) ? 4'h0 : stream[e];
  endfunction

  task automatic step(input bit v, input logic [9:0] d);
    vld = '0;
    vld[sel] = v;
    din = d;
    check("in_ready", 32'(rdy[sel]), 32'(q.size() == 0));
    @(posedge clk32f);
    model_edge(v, d);
    @(negedge clk32f);
    check("out", {o_bit[sel], o_st[sel], o_dat[sel], o_und[sel]},
          32'(exp_out()));
  endtask

  task automatic do_reset();
    vld = '0;
    reset = 1'b1;
    #1;
    check("rst_out", {o_bit[sel], o_st[sel], o_dat[sel], o_und[sel]}, 0);
    check("rst_ready", 32'(rdy[sel]), 1);
    repeat (3) @(negedge clk32f);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [9:0] d);
    bit took;
    int guard;
    guard = 0;
    do begin
      took = (q.size() == 0);
      step(1'b1, d);
      guard++;
    end while (!took && guard < 40);
    check("send_bound", 32'(took), 1);
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b0, 10'($urandom));
  endtask

  task automatic rand_run(input int cyc);
    for (int i = 0; i < cyc; i++)
      step($urandom_range(0, 3) == 0, 10'($urandom));
  endtask

  initial begin
    use_dut(0);
    model_clear();
    @(negedge clk32f);

    do_reset();
    idle(24);

    do_reset();
    step(1'b1, 10'h0A5);
    idle(16);

    do_reset();
    send(10'h011);
    send(10'h022);
    send(10'h033);
    idle(24);

    rand_run(300);

    // reset lands mid-symbol with a symbol still buffered
    do_reset();
    step(1'b1, 10'h0F0);
    step(1'b1, 10'h00F);
    idle(4);
    do_reset();
    idle(16);

    use_dut(1);
    do_reset();
    step(1'b1, 10'h001);
    idle(20);
    rand_run(200);

    use_dut(2);
    do_reset();
    idle(25);
    send(10'h3FF);
    idle(25);
    rand_run(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
